// File: rtl/cfg_loader_pkg.sv
// Shared definitions for the configuration loader: header layout, FSM states
// and the header validity rule.
package cfg_pkg;

  localparam int unsigned HDR_ID_MSB   = 31;
  localparam int unsigned HDR_ID_LSB   = 24;
  localparam int unsigned HDR_RSVD_MSB = 23;
  localparam int unsigned HDR_RSVD_LSB = 16;
  localparam int unsigned HDR_LEN_MSB  = 15;
  localparam int unsigned HDR_LEN_LSB  = 0;

  localparam int unsigned ID_WIDTH_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR   = 3'd1,
    ST_START = 3'd2,
    ST_ID    = 3'd3,
    ST_LOAD  = 3'd4,
    ST_SHIFT = 3'd5,
    ST_GAP   = 3'd6
  } state_t;

  // A header is dropped when its reserved byte is non-zero or it carries no payload.
  function automatic logic hdr_bad(input logic [31:0] hdr);
    return (hdr[HDR_RSVD_MSB:HDR_RSVD_LSB] != '0) ||
           (hdr[HDR_LEN_MSB:HDR_LEN_LSB] == '0);
  endfunction

endpackage

// File: rtl/cfg_loader_shifter.sv
// Payload word shifter: loads a host word and serialises it MSB-first,
// flagging when every bit of the word has been handed out.
module cfg_shifter #(
  parameter int unsigned WORD_W = 32
) (
  input  logic              clk,
  input  logic              crst_n,
  input  logic              load,
  input  logic              shift,
  input  logic [WORD_W-1:0] data,
  output logic              sout,
  output logic              empty
);

  localparam int unsigned CNT_W = $clog2(WORD_W + 1);

  logic [WORD_W-1:0] sreg;
  logic [CNT_W-1:0]  left;

  // The MSB leaves on the load cycle itself, so the register keeps only what is still owed.
  always_ff @(posedge clk) begin
    if (!crst_n) begin
      sreg <= '0;
      left <= '0;
    end else if (load) begin
      sreg <= {data[WORD_W-2:0], 1'b0};
      left <= CNT_W'(WORD_W - 1);
    end else if (shift) begin
      sreg <= {sreg[WORD_W-2:0], 1'b0};
      left <= left - 1'b1;
    end
  end

  always_comb begin
    sout  = load ? data[WORD_W-1] : sreg[WORD_W-1];
    empty = (left == '0);
  end

endmodule

// File: rtl/cfg_loader.sv
// Head-of-chain configuration sequencer: turns host header/payload words into
// start + ID + payload frames and counts frames sent and returned.
module cfg_loader
  import cfg_pkg::*;
#(
  parameter int unsigned WORD_W     = 32,
  parameter int unsigned ID_WIDTH   = ID_WIDTH_DEF,
  parameter int unsigned LEN_WIDTH  = 16,
  parameter int unsigned GAP_CYCLES = 2,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 crst_n,
  input  logic [WORD_W-1:0]    s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic                 cfg_in_start,
  output logic                 cfg_bit_in,
  output logic                 cfg_bit_in_valid,
  input  logic                 cfg_out_start,
  output logic                 busy,
  output logic                 frame_done,
  output logic [CNT_WIDTH-1:0] frames_sent,
  output logic [CNT_WIDTH-1:0] frames_returned,
  output logic                 err
);

  localparam int unsigned ID_CNT_W = $clog2(ID_WIDTH);

  state_t               state;
  logic [ID_WIDTH-1:0]  id_reg;
  logic [ID_CNT_W-1:0]  id_cnt;
  logic [LEN_WIDTH-1:0] rem;
  logic [3:0]           gap_cnt;

  logic accept;
  logic sh_load;
  logic sh_shift;
  logic sh_sout;
  logic sh_empty;

  always_comb begin
    accept   = s_valid && s_ready;
    sh_load  = accept && (state == ST_LOAD);
    sh_shift = (state == ST_SHIFT) && (rem != '0) && !sh_empty;
  end

  cfg_shifter #(.WORD_W(WORD_W)) u_shifter (
    .clk    (clk),
    .crst_n (crst_n),
    .load   (sh_load),
    .shift  (sh_shift),
    .data   (s_data),
    .sout   (sh_sout),
    .empty  (sh_empty)
  );

  // Outputs are registered from the state being entered; rem counts bits not yet driven.
  always_ff @(posedge clk) begin
    if (!crst_n) begin
      state            <= ST_IDLE;
      s_ready          <= 1'b0;
      cfg_in_start     <= 1'b0;
      cfg_bit_in       <= 1'b0;
      cfg_bit_in_valid <= 1'b0;
      busy             <= 1'b0;
      frame_done       <= 1'b0;
      frames_sent      <= '0;
      err              <= 1'b0;
      id_reg           <= '0;
      id_cnt           <= '0;
      rem              <= '0;
      gap_cnt          <= '0;
    end else begin
      cfg_in_start     <= 1'b0;
      cfg_bit_in       <= 1'b0;
      cfg_bit_in_valid <= 1'b0;
      frame_done       <= 1'b0;
      case (state)
        ST_IDLE: begin
          state   <= ST_HDR;
          s_ready <= 1'b1;
          busy    <= 1'b1;
        end
        ST_HDR: begin
          if (accept) begin
            if (hdr_bad(s_data)) begin
              err <= 1'b1;
            end else begin
              id_reg       <= s_data[HDR_ID_MSB:HDR_ID_LSB];
              rem          <= s_data[HDR_LEN_MSB:HDR_LEN_LSB];
              state        <= ST_START;
              s_ready      <= 1'b0;
              cfg_in_start <= 1'b1;
              frames_sent  <= frames_sent + 1'b1;
            end
          end
        end
        ST_START: begin
          state            <= ST_ID;
          cfg_bit_in_valid <= 1'b1;
          cfg_bit_in       <= id_reg[ID_WIDTH-1];
          id_reg           <= {id_reg[ID_WIDTH-2:0], 1'b0};
          id_cnt           <= '0;
        end
        ST_ID: begin
          if (id_cnt == ID_CNT_W'(ID_WIDTH - 1)) begin
            state   <= ST_LOAD;
            s_ready <= 1'b1;
          end else begin
            cfg_bit_in_valid <= 1'b1;
            cfg_bit_in       <= id_reg[ID_WIDTH-1];
            id_reg           <= {id_reg[ID_WIDTH-2:0], 1'b0};
            id_cnt           <= id_cnt + 1'b1;
          end
        end
        ST_LOAD: begin
          if (accept) begin
            state            <= ST_SHIFT;
            s_ready          <= 1'b0;
            cfg_bit_in_valid <= 1'b1;
            cfg_bit_in       <= sh_sout;
            rem              <= rem - 1'b1;
          end
        end
        ST_SHIFT: begin
          if (rem == '0) begin
            state      <= ST_GAP;
            frame_done <= 1'b1;
            gap_cnt    <= '0;
          end else if (sh_empty) begin
            state   <= ST_LOAD;
            s_ready <= 1'b1;
          end else begin
            cfg_bit_in_valid <= 1'b1;
            cfg_bit_in       <= sh_sout;
            rem              <= rem - 1'b1;
          end
        end
        ST_GAP: begin
          if (gap_cnt == 4'(GAP_CYCLES - 1)) begin
            state   <= ST_HDR;
            s_ready <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: begin
          state   <= ST_IDLE;
          s_ready <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!crst_n) begin
      frames_returned <= '0;
    end else if (cfg_out_start) begin
      frames_returned <= frames_returned + 1'b1;
    end
  end

endmodule
